// File: rtl/lock_session_ctrl.sv
// Session controller for the joystick combination lock: draws a combination from a free-running
// LFSR, gates the checker's reset, enforces per-digit timeouts and a lockout after repeated fails.
module lock_session_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned LOCKOUT_CYC = 1_500_000_000,
  parameter int unsigned MAX_FAILS   = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       key_valid_i,
  input  logic [2:0] key_press_i,
  input  logic       q_match_i,
  input  logic [2:0] joy_state_i,
  input  logic       pass_flag_i,
  output logic [2:0] num_1_o,
  output logic [2:0] num_2_o,
  output logic [2:0] num_3_o,
  output logic [2:0] num_4_o,
  output logic       checker_rst_n_o,
  output logic       unlocked_o,
  output logic       locked_out_o,
  output logic [2:0] fail_count_o,
  output logic [2:0] ctrl_state_o
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StClear    = 3'd2,
    StArmed    = 3'd3,
    StUnlocked = 3'd4,
    StFail     = 3'd5,
    StLockout  = 3'd6
  } state_e;

  localparam logic [30:0] TimeoutLoad = 31'(TIMEOUT_CYC - 1);
  localparam logic [30:0] LockoutLoad = 31'(LOCKOUT_CYC - 1);
  localparam logic [2:0]  MaxFails    = 3'(MAX_FAILS);
  localparam logic [15:0] LfsrMask    = 16'hB400;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [30:0] timer_q, timer_d;
  logic [30:0] timer_dec;
  logic [2:0]  fail_q, fail_d;
  logic [2:0]  fail_inc;
  logic [11:0] nums_q, nums_d;
  logic        crst_q, crst_d;
  logic        unl_q, unl_d;
  logic        lo_q, lo_d;

  logic [2:0]  exp_digit;
  logic        key_in_range;
  logic        key_match;
  logic        key_ok;
  logic        key_bad;

  // Galois right-shift LFSR, runs every cycle regardless of state.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);

  assign timer_dec = (timer_q == '0) ? '0 : timer_q - 31'd1;
  assign fail_inc  = fail_q + 3'd1;

  always_comb begin
    exp_digit = nums_q[2:0];
    case (joy_state_i)
      3'd1:    exp_digit = nums_q[5:3];
      3'd2:    exp_digit = nums_q[8:6];
      3'd3:    exp_digit = nums_q[11:9];
      default: exp_digit = nums_q[2:0];
    endcase
  end

  assign key_in_range = (joy_state_i <= 3'd3);
  assign key_match    = (key_press_i == exp_digit) && q_match_i;
  assign key_ok       = key_valid_i && key_in_range && key_match;
  assign key_bad      = key_valid_i && key_in_range && !key_match;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    nums_d  = nums_q;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
        nums_d  = lfsr_q[11:0];
        timer_d = TimeoutLoad;
        state_d = StClear;
      end
      StClear: begin
        state_d = StArmed;
      end
      StArmed: begin
        timer_d = timer_dec;
        if (pass_flag_i) begin
          state_d = StUnlocked;
          fail_d  = '0;
        end else if (key_bad) begin
          state_d = StFail;
        end else if (key_ok) begin
          timer_d = TimeoutLoad;
        end else if (timer_q == '0) begin
          state_d = StFail;
        end
      end
      StUnlocked: begin
        fail_d = '0;
        if (start_i) state_d = StLoad;
      end
      StFail: begin
        fail_d = fail_inc;
        if (fail_inc == MaxFails) begin
          timer_d = LockoutLoad;
          state_d = StLockout;
        end else begin
          state_d = StLoad;
        end
      end
      StLockout: begin
        timer_d = timer_dec;
        if (timer_q == '0) begin
          fail_d  = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with ctrl_state.
  always_comb begin
    crst_d = (state_d == StArmed) || (state_d == StUnlocked);
    unl_d  = (state_d == StUnlocked);
    lo_d   = (state_d == StLockout);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      timer_q <= '0;
      fail_q  <= '0;
      nums_q  <= '0;
      crst_q  <= 1'b0;
      unl_q   <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      nums_q  <= nums_d;
      crst_q  <= crst_d;
      unl_q   <= unl_d;
      lo_q    <= lo_d;
    end
  end

  assign num_1_o         = nums_q[2:0];
  assign num_2_o         = nums_q[5:3];
  assign num_3_o         = nums_q[8:6];
  assign num_4_o         = nums_q[11:9];
  assign checker_rst_n_o = crst_q;
  assign unlocked_o      = unl_q;
  assign locked_out_o    = lo_q;
  assign fail_count_o    = fail_q;
  assign ctrl_state_o    = state_q;

endmodule

// File: tb/tb_lock_session_ctrl.sv
// Scoreboard bench for lock_session_ctrl: stimulus queues expected state transitions, a monitor
// pops one on every ctrl_state change and checks all outputs every cycle.
module tb_lock_session_ctrl;

  localparam int unsigned TO   = 20;
  localparam int unsigned LO   = 30;
  localparam int unsigned MF   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [2:0] key_press = 3'd0;
  logic       q_match = 1'b0;
  logic [2:0] joy_state = 3'd0;
  logic       pass_flag = 1'b0;
  logic [2:0] num1, num2, num3, num4;
  logic       checker_rst_n, unlocked, locked_out;
  logic [2:0] fail_count, ctrl_state;

  always #5 clk = ~clk;

  lock_session_ctrl #(
    .TIMEOUT_CYC(TO),
    .LOCKOUT_CYC(LO),
    .MAX_FAILS  (MF),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .key_valid_i    (key_valid),
    .key_press_i    (key_press),
    .q_match_i      (q_match),
    .joy_state_i    (joy_state),
    .pass_flag_i    (pass_flag),
    .num_1_o        (num1),
    .num_2_o        (num2),
    .num_3_o        (num3),
    .num_4_o        (num4),
    .checker_rst_n_o(checker_rst_n),
    .unlocked_o     (unlocked),
    .locked_out_o   (locked_out),
    .fail_count_o   (fail_count),
    .ctrl_state_o   (ctrl_state)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR; m_prev is the value held during the previous cycle.
  logic [15:0] m, m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m      <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m;
      m      <= lfsr_step(m);
    end
  end

  // nmode: 0 keep digits, 1 digits from reference LFSR, 2 digits zero. dwell 0 = don't care.
  typedef struct {
    logic [2:0] st;
    logic [2:0] fc;
    logic       unl;
    logic       lo;
    logic       crst;
    int         nmode;
    int         dwell;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input logic [2:0] st, input logic [2:0] fc, input logic unl,
                      input logic lo, input logic crst, input int nmode, input int dwell);
    exp_t e;
    e.st = st; e.fc = fc; e.unl = unl; e.lo = lo; e.crst = crst;
    e.nmode = nmode; e.dwell = dwell;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t       cur;
    logic [11:0] cur_num;
    logic [2:0]  prev_st;
    int          cyc;
    int          last_cyc;
    cur.st = 3'd0; cur.fc = 3'd0; cur.unl = 1'b0; cur.lo = 1'b0; cur.crst = 1'b0;
    cur.nmode = 0; cur.dwell = 0;
    cur_num = 12'd0; prev_st = 3'd0; cyc = 0; last_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ctrl_state !== prev_st) begin
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          if (cur.dwell != 0) check("dwell", cyc - last_cyc, cur.dwell);
          if (cur.nmode == 1) cur_num = m_prev[11:0];
          else if (cur.nmode == 2) cur_num = 12'd0;
        end
        last_cyc = cyc;
        prev_st  = ctrl_state;
      end
      check("ctrl_state", ctrl_state, cur.st);
      check("fail_count", fail_count, cur.fc);
      check("unlocked", unlocked, cur.unl);
      check("locked_out", locked_out, cur.lo);
      check("checker_rst_n", checker_rst_n, cur.crst);
      check("digits", {num4, num3, num2, num1}, cur_num);
    end
  end

  logic [11:0] exp_dig, first_dig;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic start_session(input logic [2:0] fc);
    logic [15:0] nx;
    push(3'd1, fc, 1'b0, 1'b0, 1'b0, 0, 0);
    push(3'd2, fc, 1'b0, 1'b0, 1'b0, 1, 1);
    push(3'd3, fc, 1'b0, 1'b0, 1'b1, 0, 1);
    nx = lfsr_step(m);
    exp_dig = nx[11:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_pass(input int dwell);
    push(3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 0, dwell);
    pass_flag = 1'b1;
    tick();
    pass_flag = 1'b0;
  endtask

  task automatic wrong_key(input logic [2:0] fc);
    logic [15:0] nx;
    push(3'd5, fc, 1'b0, 1'b0, 1'b0, 0, 0);
    push(3'd1, fc + 3'd1, 1'b0, 1'b0, 1'b0, 0, 1);
    push(3'd2, fc + 3'd1, 1'b0, 1'b0, 1'b0, 1, 1);
    push(3'd3, fc + 3'd1, 1'b0, 1'b0, 1'b1, 0, 1);
    key_valid = 1'b1;
    joy_state = 3'd0;
    key_press = exp_dig[2:0];
    q_match   = 1'b0;
    nx = lfsr_step(lfsr_step(m));
    exp_dig = nx[11:0];
    tick();
    key_valid = 1'b0;
    repeat (3) tick();
  endtask

  // Called on the cycle ARMED is first observed; ends on the first LOCKOUT cycle.
  task automatic timeouts(input bit push_exit);
    for (int i = 0; i < 3; i++) begin
      push(3'd5, 3'(i), 1'b0, 1'b0, 1'b0, 0, TO);
      if (i < 2) begin
        push(3'd1, 3'(i + 1), 1'b0, 1'b0, 1'b0, 0, 1);
        push(3'd2, 3'(i + 1), 1'b0, 1'b0, 1'b0, 1, 1);
        push(3'd3, 3'(i + 1), 1'b0, 1'b0, 1'b1, 0, 1);
        repeat (TO + 3) tick();
      end else begin
        push(3'd6, 3'd3, 1'b0, 1'b1, 1'b0, 0, 1);
        if (push_exit) push(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 0, LO);
        repeat (TO + 1) tick();
      end
    end
  endtask

  task automatic reset_mid;
    push(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", ctrl_state, 3'd0);
    check("async_fail_count", fail_count, 3'd0);
    check("async_unlocked", unlocked, 1'b0);
    check("async_locked_out", locked_out, 1'b0);
    check("async_checker_rst_n", checker_rst_n, 1'b0);
    check("async_digits", {num4, num3, num2, num1}, 12'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    start_session(3'd0);
    check("repro_digits", {num4, num3, num2, num1}, first_dig);
  endtask

  // Stimulus
  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    start_session(3'd0);
    first_dig = exp_dig;
    repeat (4) tick();
    do_pass(5);
    repeat (3) tick();

    start_session(3'd0);
    repeat (2) tick();
    wrong_key(3'd0);
    repeat (2) tick();
    do_pass(0);
    repeat (2) tick();

    start_session(3'd0);
    timeouts(1'b1);
    repeat (5) tick();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    repeat (30) tick();

    start_session(3'd0);
    for (int j = 0; j < 4; j++) begin
      repeat (14) tick();
      key_valid = 1'b1;
      joy_state = 3'(j);
      key_press = exp_dig[j*3 +: 3];
      q_match   = 1'b1;
      tick();
      key_valid = 1'b0;
      q_match   = 1'b0;
    end
    push(3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 0, 61);
    pass_flag = 1'b1;
    key_valid = 1'b1;
    joy_state = 3'd3;
    key_press = exp_dig[11:9] ^ 3'd1;
    q_match   = 1'b1;
    tick();
    pass_flag = 1'b0;
    key_valid = 1'b0;
    q_match   = 1'b0;
    joy_state = 3'd0;
    repeat (2) tick();

    start_session(3'd0);
    repeat (5) tick();
    reset_mid();

    timeouts(1'b0);
    repeat (10) tick();
    reset_mid();

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
